perceptron_full: RTL and testbench



---
 rtl/perceptron_full_pkg.sv | 16 +
 rtl/perceptron_full_activation_unit.sv | 38 +++
 rtl/perceptron_full.sv | 84 ++++++++
 tb/tb_perceptron_full.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_full_pkg.sv
// Shared types and constants for the MLP datapath neurons.
`timescale 1ns/1ps
package Common;

    // Upper bound on neurons per layer across the network.
    localparam int MAX_LAYER_UNITS = 32;

    // Activation select for a neuron.
    typedef enum logic [1:0] {
        Sigmoid,
        Tanh,
        ReLU,
        Linear
    } act_func;

endpackage

// File: rtl/perceptron_full_activation_unit.sv
// Combinational activation: y = f(net) and its derivative f'(net).
// The derivative is expressed through y where the function allows it.
`timescale 1ns/1ps
module activation_unit
    import Common::*;
(
    input  real     net,
    input  act_func select,
    output real     y,
    output real     fprime
);

    // Evaluate the selected activation; unknown codes behave as Linear.
    always_comb begin
        y      = net;
        fprime = 1.0;
        case (select)
            Sigmoid: begin
                y      = 1.0 / (1.0 + $exp(-net));
                fprime = y * (1.0 - y);
            end
            Tanh: begin
                y      = $tanh(net);
                fprime = 1.0 - y * y;
            end
            ReLU: begin
                // Derivative at exactly zero is taken as 0.
                y      = (net > 0.0) ? net : 0.0;
                fprime = (net > 0.0) ? 1.0 : 0.0;
            end
            default: begin
                y      = net;
                fprime = 1.0;
            end
        endcase
    end

endmodule

// File: rtl/perceptron_full.sv
// Single trainable neuron: weighted sum + bias, selectable activation,
// backpropagated error gradient and per-edge gradient-descent update.
// Uses real arithmetic, so this is simulation/modelling RTL.
`timescale 1ns/1ps
module perceptron_full
    import Common::*;
#(
    parameter int input_units  = 2,
    parameter int output_units = 1,
    parameter int seed         = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  real     values [input_units-1:0],
    input  act_func activation,
    input  logic    training,
    input  real     learning_rate,
    input  real     next_layer_weights [output_units-1:0],
    input  real     error_gradient_next_layer [output_units-1:0],
    output real     prediction,
    output real     error_gradient,
    output real     current_weights [input_units-1:0]
);

    real weights [input_units-1:0];
    real bias;
    real net;
    real fprime;
    real backprop_err;
    real delta;

    // Deterministic reset pattern; seed shifts it so sibling neurons differ.
    function automatic real reset_weight(input int i);
        return real'(((3 * i + 5 * seed) % 9) - 4) * 0.125;
    endfunction

    // Weighted sum of inputs plus bias.
    always_comb begin
        net = bias;
        for (int i = 0; i < input_units; i++) begin
            net = net + weights[i] * values[i];
        end
    end

    // Error arriving from the downstream layer.
    always_comb begin
        backprop_err = 0.0;
        for (int j = 0; j < output_units; j++) begin
            backprop_err = backprop_err + next_layer_weights[j] * error_gradient_next_layer[j];
        end
    end

    activation_unit u_act (
        .net    (net),
        .select (activation),
        .y      (prediction),
        .fprime (fprime)
    );

    // Local gradient of this neuron.
    always_comb begin
        delta          = fprime * backprop_err;
        error_gradient = delta;
    end

    // Weight/bias registers: async reset to the seed pattern, otherwise
    // descend the gradient using pre-edge values whenever training is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < input_units; i++) begin
                weights[i] <= reset_weight(i);
            end
            bias <= 0.0;
        end else if (training) begin
            for (int i = 0; i < input_units; i++) begin
                weights[i] <= weights[i] - learning_rate * delta * values[i];
            end
            bias <= bias - learning_rate * delta;
        end
    end

    assign current_weights = weights;

endmodule

// File: tb/tb_perceptron_full.sv
// Self-checking bench for perceptron_full: a vector table for the
// combinational path, hand-written multi-cycle sequences, and a randomized
// training run against a behavioural model.
`timescale 1ns/1ps
module tb_perceptron_full;
    import Common::*;

    logic    clk = 1'b0;
    logic    rst;
    real     values [1:0];
    act_func activation;
    logic    training;
    real     learning_rate;
    real     nlw [0:0];
    real     egn [0:0];
    real     prediction, error_gradient;
    real     current_weights [1:0];
    real     prediction_s1, error_gradient_s1;
    real     current_weights_s1 [1:0];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    perceptron_full #(.input_units(2), .output_units(1), .seed(0)) dut (
        .clk(clk), .rst(rst), .values(values), .activation(activation),
        .training(training), .learning_rate(learning_rate),
        .next_layer_weights(nlw), .error_gradient_next_layer(egn),
        .prediction(prediction), .error_gradient(error_gradient),
        .current_weights(current_weights)
    );

    perceptron_full #(.input_units(2), .output_units(1), .seed(1)) dut_s1 (
        .clk(clk), .rst(rst), .values(values), .activation(activation),
        .training(training), .learning_rate(learning_rate),
        .next_layer_weights(nlw), .error_gradient_next_layer(egn),
        .prediction(prediction_s1), .error_gradient(error_gradient_s1),
        .current_weights(current_weights_s1)
    );

    typedef struct {
        real     x0, x1;
        act_func act;
        real     wn, dn;
        real     exp_pred, exp_grad;
    } vec_t;

    vec_t vecs [9];

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic check_real(input string name, input real act, input real expv);
        n_checks++;
        if (!(rabs(act - expv) <= 1e-9 * (1.0 + rabs(expv)))) begin
            n_fail++;
            $display("FAIL %s: got %0.12f, expected %0.12f", name, act, expv);
        end
    endtask

    // Behavioural neuron model written straight from the activation formulas.
    task automatic model_eval(input real x0, input real x1, input act_func a,
                              input real w0, input real w1, input real b,
                              input real wn, input real dn,
                              output real y, output real g);
        real n, d, ep, em;
        n = b + w0 * x0 + w1 * x1;
        case (a)
            Sigmoid: begin
                ep = $exp(-n);
                y = 1.0 / (1.0 + ep);
                d = ep / ((1.0 + ep) * (1.0 + ep));
            end
            Tanh: begin
                ep = $exp(n);
                em = $exp(-n);
                y = (ep - em) / (ep + em);
                d = 4.0 / ((ep + em) * (ep + em));
            end
            ReLU: begin
                y = (n > 0.0) ? n : 0.0;
                d = (n > 0.0) ? 1.0 : 0.0;
            end
            default: begin
                y = n;
                d = 1.0;
            end
        endcase
        g = d * wn * dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic set_in(input real x0, input real x1, input act_func a,
                          input real wn, input real dn);
        values[0] = x0;
        values[1] = x1;
        activation = a;
        nlw[0] = wn;
        egn[0] = dn;
    endtask

    real mw0, mw1, mb, ey, eg, w_save0, w_save1;

    initial begin
        rst = 1'b1;
        training = 1'b0;
        learning_rate = 0.1;
        set_in(1.0, 2.0, Linear, 1.0, 1.0);

        vecs[0] = '{1.0,  2.0, Linear,  1.0,  1.0, -0.75, 1.0};
        vecs[1] = '{1.0,  2.0, ReLU,    1.0,  1.0,  0.0,  0.0};
        vecs[2] = '{0.0,  0.0, Sigmoid, 1.0,  1.0,  0.5,  0.25};
        vecs[3] = '{0.0,  0.0, Tanh,    1.0,  1.0,  0.0,  1.0};
        vecs[4] = '{-4.0, 0.0, ReLU,    2.0,  0.5,  2.0,  1.0};
        vecs[5] = '{0.0,  8.0, Sigmoid, 1.0, -2.0,  0.2689414213699951, -0.3932238664829637};
        vecs[6] = '{2.0, -8.0, Tanh,    0.5,  3.0,  0.0,  1.5};
        vecs[7] = '{2.0, -8.0, ReLU,    1.0,  1.0,  0.0,  0.0};
        vecs[8] = '{2.0,  0.0, Linear,  3.0,  0.5, -1.0,  1.5};

        #12 rst = 1'b0;
        step();

        // Reset state, both seeds.
        check_real("rst_w0", current_weights[0], -0.5);
        check_real("rst_w1", current_weights[1], -0.125);
        check_real("rst_pred", prediction, -0.75);
        check_real("seed1_w0", current_weights_s1[0], 0.125);
        check_real("seed1_w1", current_weights_s1[1], 0.5);

        // Combinational table with reset weights, no training.
        for (int k = 0; k < 9; k++) begin
            step();
            set_in(vecs[k].x0, vecs[k].x1, vecs[k].act, vecs[k].wn, vecs[k].dn);
            #1;
            check_real($sformatf("vec%0d_pred", k), prediction, vecs[k].exp_pred);
            check_real($sformatf("vec%0d_grad", k), error_gradient, vecs[k].exp_grad);
        end

        // ReLU with zero output: three training edges leave weights alone.
        step();
        set_in(1.0, 2.0, ReLU, 1.0, 1.0);
        training = 1'b1;
        repeat (3) step();
        training = 1'b0;
        check_real("relu_pred", prediction, 0.0);
        check_real("relu_grad", error_gradient, 0.0);
        check_real("relu_w0", current_weights[0], -0.5);
        check_real("relu_w1", current_weights[1], -0.125);

        // One Linear training edge.
        set_in(1.0, 2.0, Linear, 1.0, 0.5);
        learning_rate = 0.1;
        training = 1'b1;
        step();
        training = 1'b0;
        check_real("lin_w0", current_weights[0], -0.55);
        check_real("lin_w1", current_weights[1], -0.225);
        check_real("lin_pred", prediction, -1.05);
        set_in(0.0, 0.0, Linear, 1.0, 0.5);
        #1;
        check_real("lin_bias", prediction, -0.05);

        // Hold with training low and nonzero gradient.
        set_in(1.0, 2.0, Linear, 1.0, 0.5);
        repeat (5) step();
        check_real("hold_w0", current_weights[0], -0.55);
        check_real("hold_w1", current_weights[1], -0.225);

        // Async reset between edges while training.
        training = 1'b1;
        step();
        step();
        w_save0 = current_weights[0];
        #2 rst = 1'b1;
        #1;
        check_real("async_w0", current_weights[0], -0.5);
        check_real("async_w1", current_weights[1], -0.125);
        n_checks++;
        if (w_save0 == -0.5) begin
            n_fail++;
            $display("FAIL async_pre: weight %0.12f had not moved before reset", w_save0);
        end
        step();
        check_real("rst_over_train_w0", current_weights[0], -0.5);
        #1 rst = 1'b0;
        // First update after release: delta=0.5 (Linear), eta=0.1, x={1,2}.
        step();
        check_real("release_w0", current_weights[0], -0.55);
        check_real("release_w1", current_weights[1], -0.225);
        training = 1'b0;

        // Randomized training run against the model.
        do_reset();
        mw0 = -0.5; mw1 = -0.125; mb = 0.0;
        learning_rate = 0.05;
        for (int c = 0; c < 40; c++) begin
            step();
            set_in((real'($urandom_range(0, 2000)) - 1000.0) / 1000.0,
                   (real'($urandom_range(0, 2000)) - 1000.0) / 1000.0,
                   act_func'($urandom_range(0, 3)),
                   (real'($urandom_range(0, 2000)) - 1000.0) / 1000.0,
                   (real'($urandom_range(0, 2000)) - 1000.0) / 1000.0);
            training = ($urandom_range(0, 3) != 0);
            #1;
            model_eval(values[0], values[1], activation, mw0, mw1, mb,
                       nlw[0], egn[0], ey, eg);
            check_real($sformatf("rnd%0d_pred", c), prediction, ey);
            check_real($sformatf("rnd%0d_grad", c), error_gradient, eg);
            check_real($sformatf("rnd%0d_w0", c), current_weights[0], mw0);
            check_real($sformatf("rnd%0d_w1", c), current_weights[1], mw1);
            if (training) begin
                mw0 = mw0 - learning_rate * eg * values[0];
                mw1 = mw1 - learning_rate * eg * values[1];
                mb  = mb  - learning_rate * eg;
            end
        end
        step();
        training = 1'b0;
        check_real("rnd_final_w0", current_weights[0], mw0);
        check_real("rnd_final_w1", current_weights[1], mw1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
